salva_restaura_contexto: RTL
============================

Name: salva_restaura_contexto

Overview:
Context save/restore engine: the client side of the register bank's read/write ports.
- Save: reads every architectural register through the bank's combinational read port and writes each value to data memory.
- Restore: reads memory and writes each value back through the bank's write port (RegWrite/RegEscrita/EscreveDado).
- Used by the control unit for interrupt/trap entry and exit; the processor pipeline is stalled while Ocupado=1.

Parameters:
NUM_REGS, 32, number of registers in the bank
REG_ZERO, 31, index of the hard-wired $zero register; never saved or restored
DATA_WIDTH, 32, register/memory word width
ADDR_WIDTH, 32, memory word-address width

Ports:
Clock  input  1  system clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
Iniciar  input  1  start request, sampled only in OCIOSO
Operacao  input  1  0 = save (registers -> memory), 1 = restore (memory -> registers)
BaseEndereco  input  ADDR_WIDTH  word address of the save area, captured on start
Ocupado  output  1  high from the first operating cycle until the CONCLUIDO cycle (inclusive)
Concluido  output  1  one-cycle completion pulse
RegLeitura  output  5  read index driven to the bank's read port
DadoLido  input  DATA_WIDTH  combinational read data from the bank
RegEscrita  output  5  write index to the bank
RegWrite  output  1  bank write enable
EscreveDado  output  DATA_WIDTH  bank write data
MemEndereco  output  ADDR_WIDTH  memory word address
MemDadoEscrita  output  DATA_WIDTH  memory write data
MemWrite  output  1  memory write enable
MemDadoLido  input  DATA_WIDTH  memory read data, synchronous RAM, valid one cycle after the address

Behaviour:
- Reset: state=OCIOSO, counter i=0, pipeline valid=0.
  - Reset values: Ocupado=0, Concluido=0, RegWrite=0, MemWrite=0, RegLeitura=0, RegEscrita=0, MemEndereco=0, EscreveDado=0, MemDadoEscrita=0.
  - Reset asserted mid-operation aborts at that edge. No further strobes are issued. A partially written area or bank is left as is.
- States: OCIOSO, SALVA, RESTAURA, ESVAZIA, CONCLUIDO.
- OCIOSO + Iniciar=1:
  - Capture BaseEndereco and set i=0.
  - Next state is SALVA if Operacao=0, else RESTAURA.
  - Iniciar in any other state is ignored (not queued).
- Index sequence: i steps 0,1,...,NUM_REGS-1, skipping REG_ZERO. With defaults this gives 31 indices, 0..30.
- Memory slot for register r is base+r (word address, mod 2^ADDR_WIDTH; wrap-around is allowed).
- SALVA, one register per cycle:
  - RegLeitura=i, MemEndereco=base+i, MemDadoEscrita=DadoLido (combinational pass-through), MemWrite=1.
  - After the last index: next state is CONCLUIDO.
  - Save latency: Iniciar edge + 31 cycles of MemWrite, then 1 CONCLUIDO cycle.
- RESTAURA, one read per cycle:
  - MemEndereco=base+i, MemWrite=0.
  - Index is registered into a pipeline stage (idx_d, valid_d).
  - In the following cycle: RegWrite=valid_d, RegEscrita=idx_d, EscreveDado=MemDadoLido.
  - After the last read: next state is ESVAZIA for one cycle, which performs the final write. Then CONCLUIDO.
  - Restore totals: 32 operating cycles, 31 RegWrite pulses.
- RegEscrita never equals REG_ZERO while RegWrite=1.
- RegWrite and MemWrite are never high in the same cycle.
- CONCLUIDO: Concluido=1 and Ocupado=1 for exactly one cycle, then OCIOSO.
  - Iniciar is accepted again in the cycle after CONCLUIDO (earliest back-to-back start).
- All outputs except MemDadoEscrita (in SALVA) and EscreveDado (in the write cycle) are driven from registers. Strobes are 0 in OCIOSO.

Decomposition:
- Shared package: state encoding (OCIOSO..CONCLUIDO), REG_ZERO, NUM_REGS, OP_SALVA=0, OP_RESTAURA=1.
- No sub-module needed.
- The skip-REG_ZERO index counter may be a small function in the same file.

Test Plan:
- Save: bank preloaded r0..r4 = {0,10,1,4,10}, other registers = index*3. Iniciar with Operacao=0, Base=0x100 -> exactly 31 MemWrite pulses, addresses 0x100..0x11E, mem[0x101]=10, no write to 0x11F, Concluido one pulse 32 cycles after start.
- Restore: memory 0x200+k = 0xA000+k. Operacao=1, Base=0x200 -> 31 RegWrite pulses, reg k = 0xA000+k for k=0..30, reg31 stays 0, first RegWrite one cycle after first address.
- Busy: Iniciar pulsed every cycle during a save -> only one operation runs. A second operation starts only when Iniciar is held into the cycle after Concluido.
- Reset at restore cycle 10 -> same edge: RegWrite=0, Ocupado=0. Registers 0..8 updated, 9..30 unchanged. Next Iniciar runs normally.
- Wrap: Base=0xFFFFFFF0, save -> addresses 0xFFFFFFF0..0xFFFFFFFF then 0x00000000..0x0000000E.
- Round trip: save, overwrite all registers with 0xDEAD, then restore -> bank equals its pre-save contents.

Source files
------------

// File: rtl/salva_restaura_contexto_pkg.sv
// rtl/salva_restaura_contexto_pkg.sv - shared state encoding and constants for the context save/restore engine
package salva_restaura_contexto_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        SALVA     = 3'd1,
        RESTAURA  = 3'd2,
        ESVAZIA   = 3'd3,
        CONCLUIDO = 3'd4
    } estado_t;

    localparam int   NUM_REGS_PADRAO = 32;
    localparam int   REG_ZERO_PADRAO = 31;
    localparam logic OP_SALVA        = 1'b0;
    localparam logic OP_RESTAURA     = 1'b1;

endpackage

// File: rtl/salva_restaura_contexto.sv
// rtl/salva_restaura_contexto.sv - context save/restore engine driving the register bank and data memory
module salva_restaura_contexto
    import salva_restaura_contexto_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_PADRAO,
    parameter int REG_ZERO   = REG_ZERO_PADRAO,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Iniciar,
    input  logic                  Operacao,
    input  logic [ADDR_WIDTH-1:0] BaseEndereco,
    output logic                  Ocupado,
    output logic                  Concluido,
    output logic [4:0]            RegLeitura,
    input  logic [DATA_WIDTH-1:0] DadoLido,
    output logic [4:0]            RegEscrita,
    output logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] EscreveDado,
    output logic [ADDR_WIDTH-1:0] MemEndereco,
    output logic [DATA_WIDTH-1:0] MemDadoEscrita,
    output logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] MemDadoLido
);

    localparam logic [4:0] PRIMEIRO = (REG_ZERO == 0) ? 5'd1 : 5'd0;
    localparam logic [4:0] ULTIMO   = (REG_ZERO == NUM_REGS - 1) ? 5'(NUM_REGS - 2) : 5'(NUM_REGS - 1);

    // Next register index, stepping over the hard-wired zero register.
    function automatic logic [4:0] proximo(input logic [4:0] idx);
        logic [4:0] n;
        n = idx + 5'd1;
        if (n == 5'(REG_ZERO)) begin
            n = n + 5'd1;
        end
        return n;
    endfunction

    estado_t               estado_q;
    logic [4:0]            i_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [4:0]            pipe_idx_q;
    logic                  pipe_valid_q;
    logic                  ocupado_q;
    logic                  concluido_q;
    logic                  mem_write_q;
    logic [4:0]            reg_leitura_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [4:0]            prox_d;

    always_comb begin
        prox_d = proximo(i_q);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q      <= OCIOSO;
            i_q           <= '0;
            base_q        <= '0;
            pipe_idx_q    <= '0;
            pipe_valid_q  <= 1'b0;
            ocupado_q     <= 1'b0;
            concluido_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_leitura_q <= '0;
            mem_addr_q    <= '0;
        end else begin
            concluido_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    pipe_valid_q <= 1'b0;
                    mem_write_q  <= 1'b0;
                    if (Iniciar) begin
                        base_q     <= BaseEndereco;
                        i_q        <= PRIMEIRO;
                        mem_addr_q <= BaseEndereco + ADDR_WIDTH'(PRIMEIRO);
                        ocupado_q  <= 1'b1;
                        if (Operacao == OP_SALVA) begin
                            estado_q      <= SALVA;
                            reg_leitura_q <= PRIMEIRO;
                            mem_write_q   <= 1'b1;
                        end else begin
                            estado_q <= RESTAURA;
                        end
                    end
                end
                SALVA: begin
                    if (i_q == ULTIMO) begin
                        estado_q    <= CONCLUIDO;
                        mem_write_q <= 1'b0;
                        concluido_q <= 1'b1;
                    end else begin
                        i_q           <= prox_d;
                        reg_leitura_q <= prox_d;
                        mem_addr_q    <= base_q + ADDR_WIDTH'(prox_d);
                    end
                end
                RESTAURA: begin
                    // Memory answers one cycle later, so the bank write trails the read by one stage.
                    pipe_valid_q <= 1'b1;
                    pipe_idx_q   <= i_q;
                    if (i_q == ULTIMO) begin
                        estado_q <= ESVAZIA;
                    end else begin
                        i_q        <= prox_d;
                        mem_addr_q <= base_q + ADDR_WIDTH'(prox_d);
                    end
                end
                ESVAZIA: begin
                    pipe_valid_q <= 1'b0;
                    estado_q     <= CONCLUIDO;
                    concluido_q  <= 1'b1;
                end
                CONCLUIDO: begin
                    estado_q  <= OCIOSO;
                    ocupado_q <= 1'b0;
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign Ocupado        = ocupado_q;
    assign Concluido      = concluido_q;
    assign RegLeitura     = reg_leitura_q;
    assign RegEscrita     = pipe_idx_q;
    assign RegWrite       = pipe_valid_q;
    assign MemEndereco    = mem_addr_q;
    assign MemWrite       = mem_write_q;
    assign MemDadoEscrita = (estado_q == SALVA) ? DadoLido : '0;
    assign EscreveDado    = pipe_valid_q ? MemDadoLido : '0;

endmodule
